test_image_loader: RTL and testbench
====================================

// Module: test_image_loader
// PURPOSE
// Simulation-side program loader and run supervisor for the rv32im_vector core.
// - Clears main memory, streams an ISA test image into it byte by byte, then releases the core from reset.
// - Watches the exit-syscall convention (a7 == EXIT_CODE) and reports pass/fail from a0, with a cycle timeout.
// - Replaces per-test hierarchical memory pokes with a synthesizable, reusable front end for regression.
// PARAMETERS
// MEM_BYTES       131072      bytes of main memory to clear and load
// ADDR_W          17          byte address width, 2**ADDR_W >= MEM_BYTES
// EXIT_CODE       32'h5d      a7 value that signals test end
// SETTLE_CYCLES   5           cycles to wait after exit detect before sampling a0
// TIMEOUT_CYCLES  20000000    max RUN cycles before timeout is declared
// PORTS
// clk           in   1       clock
// rst           in   1       asynchronous active-high reset
// start         in   1       1-cycle pulse, begins a test; honoured in IDLE and REPORT only
// src_valid     in   1       image byte valid
// src_ready     out  1       loader accepts image byte
// src_addr      in   ADDR_W  byte address of image byte
// src_data      in   8       image byte
// src_last      in   1       final image byte
// mem_we        out  1       main-memory byte write strobe
// mem_addr      out  ADDR_W  main-memory byte address
// mem_wdata     out  8       main-memory write data
// core_rst_n    out  1       core reset, active-low, 1 only in RUN/SETTLE
// a7_val        in   32      core register x17, live value
// a0_val        in   32      core register x10, live value
// busy          out  1       state is CLEAR, LOAD, RUN or SETTLE
// done          out  1       result valid; held until next start
// pass          out  1       a0 was 0 at sample time; valid when done
// timeout       out  1       run exceeded TIMEOUT_CYCLES; valid when done
// fail_code     out  32      sampled a0 (0 on pass or timeout)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (core_rst_n = 0, core held in reset); counters 0.
// - Reset mid-operation aborts immediately: partial image discarded, core re-held in reset.
// - All outputs registered.
// - IDLE: start -> CLEAR. Entering CLEAR from IDLE or REPORT clears done/pass/timeout/fail_code and cnt.
// - CLEAR: one write per cycle, mem_we = 1, mem_addr = cnt, mem_wdata = 0.
//   - cnt runs 0..MEM_BYTES-1; after the last write -> LOAD. Duration is exactly MEM_BYTES cycles.
// - LOAD: src_ready = 1. A handshake (src_valid & src_ready) produces a write one cycle later:
//   mem_we = 1, mem_addr = src_addr, mem_wdata = src_data.
//   - src_addr >= MEM_BYTES: the byte is accepted and dropped (no write).
//   - A handshake with src_last -> RUN. core_rst_n = 1 from the first RUN cycle; run counter = 0.
// - RUN: run counter increments each cycle.
//   - a7_val == EXIT_CODE -> SETTLE.
//   - Run counter == TIMEOUT_CYCLES-1 -> REPORT with timeout = 1, pass = 0, fail_code = 0.
//   - Exit and timeout in the same cycle: exit wins.
// - SETTLE: wait SETTLE_CYCLES cycles (exit is sticky; later a7 changes are ignored), then sample a0_val:
//   pass = (a0_val == 0), fail_code = a0_val -> REPORT.
// - REPORT: core_rst_n = 0 from the first REPORT cycle; done = 1. start -> CLEAR for the next test.
// - src_ready = 0 outside LOAD. mem_we = 0 outside CLEAR/LOAD. start outside IDLE/REPORT is ignored.
// TESTING
// Test parameters: MEM_BYTES = 16, ADDR_W = 4, SETTLE_CYCLES = 5, TIMEOUT_CYCLES = 100.
// 1 clear: start -> 16 consecutive cycles with mem_we = 1, addr 0..15, data 0.
//   LOAD begins on cycle 17 with src_ready = 1.
// 2 load: bytes {0:13, 1:05, 15:aa (last)} with src_valid gaps
//   -> exactly 3 writes, each 1 cycle after its handshake; core_rst_n rises the cycle after the last write.
// 3 pass: in RUN, drive a7 = 0x5d, a0 = 0 -> 5 cycles later done = 1, pass = 1, fail_code = 0, core_rst_n = 0.
// 4 fail: a7 = 0x5d, a0 = 7 -> done = 1, pass = 0, fail_code = 7.
//   Changing a7 during SETTLE does not alter the result.
// 5 timeout: never drive exit -> after 100 RUN cycles done = 1, timeout = 1, pass = 0.
//   Exit on cycle 100 instead -> SETTLE path taken.
// 6 abort/restart: assert rst during LOAD -> all outputs 0 at once.
//   Then start from REPORT -> CLEAR with done cleared.

Source files
------------

// File: rtl/test_image_loader.sv
// Simulation-side program loader and run supervisor: clears memory, streams a test
// image in, releases the core from reset and reports pass/fail/timeout from a7/a0.
module test_image_loader #(
  parameter int          MEM_BYTES      = 131072,
  parameter int          ADDR_W         = 17,
  parameter logic [31:0] EXIT_CODE      = 32'h5d,
  parameter int          SETTLE_CYCLES  = 5,
  parameter int          TIMEOUT_CYCLES = 20000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  input  logic              src_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_rst_n,
  input  logic [31:0]       a7_val,
  input  logic [31:0]       a0_val,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       fail_code
);

  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_REPORT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              load_done;

  // LOAD lingers one extra cycle after the last handshake so the final byte is
  // written before the core leaves reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      load_done  <= 1'b0;
      src_ready  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_REPORT: begin
          if (start) begin
            state      <= S_CLEAR;
            cnt        <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_code  <= '0;
          end
        end

        S_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state     <= S_LOAD;
            src_ready <= 1'b1;
            load_done <= 1'b0;
          end else begin
            cnt       <= cnt + ADDR_W'(1);
            mem_we    <= 1'b1;
            mem_addr  <= cnt + ADDR_W'(1);
            mem_wdata <= '0;
          end
        end

        S_LOAD: begin
          if (load_done) begin
            state      <= S_RUN;
            core_rst_n <= 1'b1;
            run_cnt    <= '0;
          end else if (src_valid && src_ready) begin
            // Bytes addressed beyond the memory are consumed but never written.
            if ({1'b0, src_addr} < MEM_LIMIT) begin
              mem_we    <= 1'b1;
              mem_addr  <= src_addr;
              mem_wdata <= src_data;
            end
            if (src_last) begin
              load_done <= 1'b1;
              src_ready <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (a7_val == EXIT_CODE) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end else if (run_cnt == RUN_LAST) begin
            state      <= S_REPORT;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
            fail_code  <= '0;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state      <= S_REPORT;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (a0_val == 32'd0);
            timeout    <= 1'b0;
            fail_code  <= a0_val;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_image_loader.sv
// Bench for test_image_loader: memory writes are tracked by a scoreboard queue,
// run outcomes come from a table of exit/a0 scenarios with their expected results.
module tb_test_image_loader;

  localparam int          MEM_BYTES      = 16;
  localparam int          ADDR_W         = 4;
  localparam int          SETTLE_CYCLES  = 5;
  localparam int          TIMEOUT_CYCLES = 100;
  localparam logic [31:0] EXIT_CODE      = 32'h5d;

  logic              clk;
  logic              rst;
  logic              start;
  logic              src_valid;
  logic              src_ready;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;
  logic              src_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              core_rst_n;
  logic [31:0]       a7_val;
  logic [31:0]       a0_val;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [31:0]       fail_code;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                at;
  } wr_t;

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              last;
  } byte_vec_t;

  typedef struct {
    int          exit_at;
    logic [31:0] a0;
    logic        poke_a7;
    int          done_at;
    logic        exp_pass;
    logic        exp_timeout;
    logic [31:0] exp_code;
  } run_vec_t;

  wr_t       exp_q[$];
  wr_t       got;
  byte_vec_t image[6];
  run_vec_t  runs[5];

  test_image_loader #(
    .MEM_BYTES     (MEM_BYTES),
    .ADDR_W        (ADDR_W),
    .EXIT_CODE     (EXIT_CODE),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .src_last  (src_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst_n(core_rst_n),
    .a7_val    (a7_val),
    .a0_val    (a0_val),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .fail_code (fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Every observed write must match the oldest outstanding expectation, in its cycle.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                 mem_addr, mem_wdata, cyc);
      end else begin
        got = exp_q.pop_front();
        checkOutput("write_addr", 32'(mem_addr), 32'(got.addr));
        checkOutput("write_data", 32'(mem_wdata), 32'(got.data));
        checkOutput("write_cycle", 32'(cyc), 32'(got.at));
      end
    end
  end

  task automatic start_and_clear();
    int s_cyc;
    next_cycle();
    start = 1'b1;
    s_cyc = cyc;
    for (int i = 0; i < MEM_BYTES; i++)
      exp_q.push_back('{addr: ADDR_W'(i), data: 8'h00, at: s_cyc + 1 + i});
    next_cycle();
    start = 1'b0;
    sample();
    checkOutput("clear_busy", 32'(busy), 32'd1);
    checkOutput("clear_done_cleared", 32'(done), 32'd0);
    checkOutput("clear_pass_cleared", 32'(pass), 32'd0);
    checkOutput("clear_timeout_cleared", 32'(timeout), 32'd0);
    checkOutput("clear_code_cleared", fail_code, 32'd0);
    checkOutput("clear_src_ready", 32'(src_ready), 32'd0);
    repeat (MEM_BYTES) next_cycle();
  endtask

  task automatic applyStimulus(input run_vec_t rv);
    int  last_cyc;
    int  k;
    bit  seen;
    start_and_clear();
    last_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      src_valid = image[i].valid;
      src_addr  = image[i].addr;
      src_data  = image[i].data;
      src_last  = image[i].last;
      if (image[i].valid)
        exp_q.push_back('{addr: image[i].addr, data: image[i].data, at: cyc + 1});
      if (image[i].valid && image[i].last) last_cyc = cyc;
      sample();
      checkOutput("load_src_ready", 32'(src_ready), 32'd1);
      checkOutput("load_core_held", 32'(core_rst_n), 32'd0);
    end
    next_cycle();
    src_valid = 1'b0;
    src_last  = 1'b0;
    sample();
    checkOutput("last_write_core_held", 32'(core_rst_n), 32'd0);
    checkOutput("last_write_ready_low", 32'(src_ready), 32'd0);
    next_cycle();
    sample();
    checkOutput("run_release_cycle", 32'(cyc - last_cyc), 32'd2);
    checkOutput("run_core_rst_n", 32'(core_rst_n), 32'd1);
    checkOutput("load_writes_drained", 32'(exp_q.size()), 32'd0);

    k    = 0;
    seen = 1'b0;
    while (k < 200 && !seen) begin
      start  = (k == 1);
      a0_val = rv.a0;
      if (k == rv.exit_at)
        a7_val = EXIT_CODE;
      else if (rv.poke_a7 && rv.exit_at >= 0 && k > rv.exit_at)
        a7_val = 32'h100 + 32'(k);
      else if (rv.poke_a7 && rv.exit_at >= 0)
        a7_val = 32'h0;
      else
        a7_val = EXIT_CODE - 32'd1;
      sample();
      if (done) begin
        seen = 1'b1;
      end else begin
        checkOutput("running_core_rst_n", 32'(core_rst_n), 32'd1);
        checkOutput("running_busy", 32'(busy), 32'd1);
        k++;
      end
    end
    start  = 1'b0;
    a7_val = 32'h0;
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("done_cycle", 32'(k + 1), 32'(rv.done_at));
    checkOutput("report_pass", 32'(pass), 32'(rv.exp_pass));
    checkOutput("report_timeout", 32'(timeout), 32'(rv.exp_timeout));
    checkOutput("report_fail_code", fail_code, rv.exp_code);
    checkOutput("report_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("report_busy", 32'(busy), 32'd0);
    sample();
    checkOutput("report_done_held", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, "_fail_code"}, fail_code, 32'd0);
    checkOutput({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    checkOutput({tag, "_src_ready"}, 32'(src_ready), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    image[0] = '{1'b1, 4'd0,  8'h13, 1'b0};
    image[1] = '{1'b0, 4'd7,  8'hee, 1'b0};
    image[2] = '{1'b1, 4'd1,  8'h05, 1'b0};
    image[3] = '{1'b0, 4'd9,  8'h44, 1'b1};
    image[4] = '{1'b0, 4'd2,  8'h66, 1'b0};
    image[5] = '{1'b1, 4'd15, 8'haa, 1'b1};

    runs[0] = '{3,  32'd0,         1'b0, 3 + 1 + SETTLE_CYCLES, 1'b1, 1'b0, 32'd0};
    runs[1] = '{3,  32'd7,         1'b1, 3 + 1 + SETTLE_CYCLES, 1'b0, 1'b0, 32'd7};
    runs[2] = '{-1, 32'h55,        1'b0, TIMEOUT_CYCLES,        1'b0, 1'b1, 32'd0};
    runs[3] = '{TIMEOUT_CYCLES - 1, 32'h1234, 1'b0, TIMEOUT_CYCLES + SETTLE_CYCLES, 1'b0, 1'b0, 32'h1234};
    runs[4] = '{0,  32'hdeadbeef,  1'b1, 1 + SETTLE_CYCLES,     1'b0, 1'b0, 32'hdeadbeef};

    rst       = 1'b1;
    start     = 1'b0;
    src_valid = 1'b0;
    src_addr  = '0;
    src_data  = '0;
    src_last  = 1'b0;
    a7_val    = 32'h0;
    a0_val    = 32'h0;
    repeat (2) @(posedge clk);
    sample();
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(runs[i]);

    // Restart from REPORT, then abort with reset in the middle of the image load.
    start_and_clear();
    src_valid = 1'b1;
    src_addr  = 4'd2;
    src_data  = 8'h77;
    src_last  = 1'b0;
    exp_q.push_back('{addr: 4'd2, data: 8'h77, at: cyc + 1});
    sample();
    checkOutput("abort_load_ready", 32'(src_ready), 32'd1);
    next_cycle();
    src_addr = 4'd3;
    src_data = 8'h99;
    sample();
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    src_valid = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    sample();
    checkOutput("abort_writes_drained", 32'(exp_q.size()), 32'd0);
    check_all_zero("after_abort");

    applyStimulus(runs[0]);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
